// File: rtl/light_display.sv
// Traffic-light display driver: sequential binary-to-BCD, 4-digit multiplexed 7-segment scan, lamp decode.
// Optional yellow/emergency lamp blinking is enabled by defining LIGHT_BLINK_EN.
module light_display #(
   parameter int SCAN_DIV  = 50000,
   parameter int BLINK_DIV = 25000000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] num,
   input  logic [2:0] color,
   output logic [3:0] an,
   output logic [6:0] seg,
   output logic [5:0] lamp,
   output logic       busy
);

   localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [6:0] SEG_BLANK = 7'b1111111;

   typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_COMMIT} state_t;

   state_t            state_q, state_d;
   logic [7:0]        last_num_q, last_num_d;
   logic [7:0]        shreg_q, shreg_d;
   logic [11:0]       scratch_q, scratch_d;
   logic [11:0]       adj;
   logic [2:0]        iter_q, iter_d;
   logic [3:0]        hund_q, hund_d;
   logic [3:0]        tens_q, tens_d;
   logic [3:0]        ones_q, ones_d;
   logic [SCAN_W-1:0] scan_q, scan_d;
   logic [1:0]        digit_q, digit_d;
   logic [3:0]        an_q, an_d;
   logic [6:0]        seg_q, seg_d;
   logic [5:0]        lamp_q, lamp_d;
   logic [5:0]        lamp_base;
   logic              blink_on;

   function automatic logic [6:0] glyph(input logic [3:0] v);
      logic [6:0] s;
      case (v)
         4'd0:    s = 7'b1000000;
         4'd1:    s = 7'b1111001;
         4'd2:    s = 7'b0100100;
         4'd3:    s = 7'b0110000;
         4'd4:    s = 7'b0011001;
         4'd5:    s = 7'b0010010;
         4'd6:    s = 7'b0000010;
         4'd7:    s = 7'b1111000;
         4'd8:    s = 7'b0000000;
         4'd9:    s = 7'b0010000;
         default: s = SEG_BLANK;
      endcase
      return s;
   endfunction

   // Double-dabble correction: any BCD nibble of 5 or more gets +3 before the shift.
   function automatic logic [11:0] dabble_adjust(input logic [11:0] b);
      logic [11:0] r;
      for (int i = 0; i < 3; i++) begin
         r[4*i +: 4] = (b[4*i +: 4] >= 4'd5) ? b[4*i +: 4] + 4'd3 : b[4*i +: 4];
      end
      return r;
   endfunction

   always_comb begin
      state_d    = state_q;
      last_num_d = last_num_q;
      shreg_d    = shreg_q;
      scratch_d  = scratch_q;
      iter_d     = iter_q;
      hund_d     = hund_q;
      tens_d     = tens_q;
      ones_d     = ones_q;
      adj        = dabble_adjust(scratch_q);
      case (state_q)
         S_IDLE: begin
            if (num != last_num_q) begin
               last_num_d = num;
               shreg_d    = num;
               scratch_d  = '0;
               iter_d     = '0;
               state_d    = S_SHIFT;
            end
         end
         S_SHIFT: begin
            scratch_d = {adj[10:0], shreg_q[7]};
            shreg_d   = {shreg_q[6:0], 1'b0};
            iter_d    = iter_q + 3'd1;
            if (iter_q == 3'd7) state_d = S_COMMIT;
         end
         S_COMMIT: begin
            hund_d  = scratch_q[11:8];
            tens_d  = scratch_q[7:4];
            ones_d  = scratch_q[3:0];
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // an and seg load together on the scan wrap, so a slot never mixes old and new.
   always_comb begin
      scan_d  = scan_q + SCAN_W'(1);
      digit_d = digit_q;
      an_d    = an_q;
      seg_d   = seg_q;
      if (scan_q == SCAN_W'(SCAN_DIV - 1)) begin
         scan_d  = '0;
         digit_d = digit_q + 2'd1;
         an_d    = ~(4'b0001 << digit_q);
         case (digit_q)
            2'd0:    seg_d = glyph(ones_q);
            2'd1:    seg_d = (hund_q == 4'd0 && tens_q == 4'd0) ? SEG_BLANK : glyph(tens_q);
            2'd2:    seg_d = (hund_q == 4'd0) ? SEG_BLANK : glyph(hund_q);
            default: seg_d = glyph({1'b0, color});
         endcase
      end
   end

   always_comb begin
      case (color)
         3'b000:  lamp_base = 6'b001100;
         3'b001:  lamp_base = 6'b010100;
         3'b010:  lamp_base = 6'b100001;
         3'b011:  lamp_base = 6'b100010;
         3'b100:  lamp_base = 6'b001100;
         3'b101:  lamp_base = 6'b010100;
         default: lamp_base = 6'b100100;
      endcase
      lamp_d    = lamp_base;
      lamp_d[4] = lamp_base[4] & blink_on;
      lamp_d[1] = lamp_base[1] & blink_on;
      if (color == 3'b110) begin
         lamp_d[5] = lamp_base[5] & blink_on;
         lamp_d[2] = lamp_base[2] & blink_on;
      end
   end

`ifdef LIGHT_BLINK_EN
   localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

   logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
   logic               phase_q, phase_d;

   always_comb begin
      blink_cnt_d = blink_cnt_q + BLINK_W'(1);
      phase_d     = phase_q;
      if (blink_cnt_q == BLINK_W'(BLINK_DIV - 1)) begin
         blink_cnt_d = '0;
         phase_d     = ~phase_q;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         blink_cnt_q <= '0;
         phase_q     <= 1'b1;
      end else begin
         blink_cnt_q <= blink_cnt_d;
         phase_q     <= phase_d;
      end
   end

   assign blink_on = phase_q;
`else
   // Steady lamps: the blink divider only exists in the blinking build.
   assign blink_on = (BLINK_DIV > 1);
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         last_num_q <= '0;
         shreg_q    <= '0;
         scratch_q  <= '0;
         iter_q     <= '0;
         hund_q     <= '0;
         tens_q     <= '0;
         ones_q     <= '0;
         scan_q     <= '0;
         digit_q    <= '0;
         an_q       <= 4'b1111;
         seg_q      <= SEG_BLANK;
         lamp_q     <= 6'b100100;
      end else begin
         state_q    <= state_d;
         last_num_q <= last_num_d;
         shreg_q    <= shreg_d;
         scratch_q  <= scratch_d;
         iter_q     <= iter_d;
         hund_q     <= hund_d;
         tens_q     <= tens_d;
         ones_q     <= ones_d;
         scan_q     <= scan_d;
         digit_q    <= digit_d;
         an_q       <= an_d;
         seg_q      <= seg_d;
         lamp_q     <= lamp_d;
      end
   end

   assign an   = an_q;
   assign seg  = seg_q;
   assign lamp = lamp_q;
   assign busy = (state_q != S_IDLE);

endmodule

// File: tb/tb_light_display.sv
// Table-driven bench for light_display (SCAN_DIV=4, BLINK_DIV=3); blink checks follow LIGHT_BLINK_EN.
module tb_light_display;

   localparam int SDIV = 4;
   localparam logic [6:0] BL = 7'b1111111;
   localparam logic [6:0] G [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                     7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                     7'b0000000, 7'b0010000};

   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] num;
   logic [2:0] color;
   logic [3:0] an;
   logic [6:0] seg;
   logic [5:0] lamp;
   logic       busy;

   int n_vec  = 0;
   int n_miss = 0;
   int viol;
   logic [6:0] cap [4];
   logic [3:0] cap_seen;
   logic       cap_bad_an;

   typedef struct {
      logic [7:0] num;
      logic [2:0] color;
      logic [6:0] d3, d2, d1, d0;
      logic [5:0] lamp;
   } vec_t;

   typedef struct {
      logic [2:0] color;
      logic [5:0] lamp;
   } lvec_t;

   vec_t  vt [7];
   lvec_t lt [8];

   light_display #(.SCAN_DIV(SDIV), .BLINK_DIV(3)) dut (
      .clk(clk), .rst_n(rst_n), .num(num), .color(color),
      .an(an), .seg(seg), .lamp(lamp), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [5:0] blink_mask(input logic [2:0] c);
`ifdef LIGHT_BLINK_EN
      return 6'b010010 | ((c == 3'b110) ? 6'b100100 : 6'b000000);
`else
      return (c == 3'b111) ? 6'b000000 : 6'b000000;
`endif
   endfunction

   task automatic capture_frame();
      cap_seen   = 4'b0000;
      cap_bad_an = 1'b0;
      for (int i = 0; i < 4; i++) cap[i] = 7'b0000000;
      for (int c = 0; c < 4*SDIV; c++) begin
         tick();
         case (an)
            4'b1110: begin cap[0] = seg; cap_seen[0] = 1'b1; end
            4'b1101: begin cap[1] = seg; cap_seen[1] = 1'b1; end
            4'b1011: begin cap[2] = seg; cap_seen[2] = 1'b1; end
            4'b0111: begin cap[3] = seg; cap_seen[3] = 1'b1; end
            default: cap_bad_an = 1'b1;
         endcase
      end
   endtask

   task automatic sample_mid();
      case (an)
         4'b1110: if (!(seg == G[0] || seg == G[9] || seg == G[8])) viol++;
         4'b1101: if (!(seg == G[3] || seg == G[2])) viol++;
         default: ;
      endcase
   endtask

   initial begin
      logic [9:0]  bpat;
      logic [19:0] mpat;
      logic [11:0] s;
      logic [5:0]  prev_lamp;
      logic [2:0]  prev_color;
      int          tog;

      vt[0] = '{8'd237, 3'd5, G[5], G[2], G[3], G[7], 6'b010100};
      vt[1] = '{8'd5,   3'd2, G[2], BL,   BL,   G[5], 6'b100001};
      vt[2] = '{8'd40,  3'd7, G[7], BL,   G[4], G[0], 6'b100100};
      vt[3] = '{8'd100, 3'd0, G[0], G[1], G[0], G[0], 6'b001100};
      vt[4] = '{8'd255, 3'd3, G[3], G[2], G[5], G[5], 6'b100010};
      vt[5] = '{8'd0,   3'd4, G[4], BL,   BL,   G[0], 6'b001100};
      vt[6] = '{8'd9,   3'd1, G[1], BL,   BL,   G[9], 6'b010100};
      lt[0] = '{3'd0, 6'b001100}; lt[1] = '{3'd1, 6'b010100};
      lt[2] = '{3'd2, 6'b100001}; lt[3] = '{3'd3, 6'b100010};
      lt[4] = '{3'd4, 6'b001100}; lt[5] = '{3'd5, 6'b010100};
      lt[6] = '{3'd6, 6'b100100}; lt[7] = '{3'd7, 6'b100100};

      // Reset state and first scan wrap
      rst_n = 1'b0; num = 8'd0; color = 3'd0;
      tick();
      check("rst_an", 32'(an), 32'(4'b1111));
      check("rst_seg", 32'(seg), 32'(BL));
      check("rst_lamp", 32'(lamp), 32'(6'b100100));
      check("rst_busy", 32'(busy), 32'(1'b0));
      rst_n = 1'b1;
      for (int i = 0; i < SDIV - 1; i++) tick();
      check("prewrap_an", 32'(an), 32'(4'b1111));
      tick();
      check("wrap_an", 32'(an), 32'(4'b1110));
      check("wrap_seg", 32'(seg), 32'(G[0]));

      // Conversion / digit / lamp table
      for (int v = 0; v < 7; v++) begin
         num = vt[v].num; color = vt[v].color;
         bpat = '0;
         for (int k = 0; k < 10; k++) begin
            tick();
            bpat[k] = busy;
            if (k == 0)
               check($sformatf("lamp_v%0d", v), 32'(lamp & ~blink_mask(vt[v].color)),
                     32'(vt[v].lamp & ~blink_mask(vt[v].color)));
         end
         check($sformatf("busy_v%0d", v), 32'(bpat), 32'(10'b0111111111));
         for (int k = 0; k < 4*SDIV; k++) tick();
         capture_frame();
         check($sformatf("an_v%0d", v), 32'({cap_bad_an, cap_seen}), 32'(5'b01111));
         check($sformatf("d0_v%0d", v), 32'(cap[0]), 32'(vt[v].d0));
         check($sformatf("d1_v%0d", v), 32'(cap[1]), 32'(vt[v].d1));
         check($sformatf("d2_v%0d", v), 32'(cap[2]), 32'(vt[v].d2));
         check($sformatf("d3_v%0d", v), 32'(cap[3]), 32'(vt[v].d3));
      end

      // Lamp sweep with one-cycle latency
      color = 3'b111; tick();
      prev_lamp = 6'b100100; prev_color = 3'b111;
      for (int i = 0; i < 8; i++) begin
         color = lt[i].color;
         check($sformatf("lamp_hold_%0d", i), 32'(lamp & ~blink_mask(prev_color)),
               32'(prev_lamp & ~blink_mask(prev_color)));
         tick();
         check($sformatf("lamp_sweep_%0d", i), 32'(lamp & ~blink_mask(lt[i].color)),
               32'(lt[i].lamp & ~blink_mask(lt[i].color)));
         prev_lamp = lt[i].lamp; prev_color = lt[i].color;
      end

      // num changes while a conversion is in flight
      color = 3'd2; num = 8'd30;
      for (int k = 0; k < 32; k++) tick();
      viol = 0; mpat = '0;
      num = 8'd29;
      for (int k = 0; k < 20; k++) begin
         tick();
         mpat[k] = busy;
         sample_mid();
         if (k == 3) num = 8'd28;
      end
      check("midconv_busy", 32'(mpat), 32'(20'h7FDFF));
      for (int k = 0; k < 4*SDIV; k++) begin tick(); sample_mid(); end
      capture_frame();
      check("midconv_viol", 32'(viol), 32'(0));
      check("midconv_d0", 32'(cap[0]), 32'(G[8]));
      check("midconv_d1", 32'(cap[1]), 32'(G[2]));
      check("midconv_d2", 32'(cap[2]), 32'(BL));

      // Reset during a conversion, then reconversion of a nonzero num
      num = 8'd77;
      tick(); tick(); tick();
      rst_n = 1'b0;
      tick();
      check("midrst_busy", 32'(busy), 32'(1'b0));
      check("midrst_an", 32'(an), 32'(4'b1111));
      check("midrst_seg", 32'(seg), 32'(BL));
      check("midrst_lamp", 32'(lamp), 32'(6'b100100));
      rst_n = 1'b1;
      tick();
      check("postrst_busy", 32'(busy), 32'(1'b1));
      for (int k = 0; k < 9; k++) tick();
      check("postrst_done", 32'(busy), 32'(1'b0));
      capture_frame();
      check("postrst_d0", 32'(cap[0]), 32'(G[7]));
      check("postrst_d1", 32'(cap[1]), 32'(G[7]));
      check("postrst_d2", 32'(cap[2]), 32'(BL));
      check("postrst_d3", 32'(cap[3]), 32'(G[2]));

      // Yellow blink (color 001) and emergency red flash (color 110)
      color = 3'b001; tick(); tick();
      for (int k = 0; k < 12; k++) begin s[k] = lamp[4]; viol += (lamp[2] != 1'b1) ? 1 : 0; tick(); end
      tog = 0;
      for (int k = 1; k < 12; k++) tog += (s[k] != s[k-1]) ? 1 : 0;
`ifdef LIGHT_BLINK_EN
      for (int k = 0; k < 9; k++) viol += (s[k+3] == s[k]) ? 1 : 0;
      check("blink_y_toggles", 32'((tog == 3 || tog == 4) ? 1 : 0), 32'(1));
`else
      check("steady_y", 32'(s), 32'(12'hFFF));
`endif
      check("blink_y_pattern", 32'(viol), 32'(0));
      color = 3'b110; tick(); tick();
      viol = 0;
      for (int k = 0; k < 12; k++) begin s[k] = lamp[5]; viol += (lamp[2] != lamp[5]) ? 1 : 0; tick(); end
`ifdef LIGHT_BLINK_EN
      for (int k = 0; k < 9; k++) viol += (s[k+3] == s[k]) ? 1 : 0;
`else
      check("steady_red", 32'(s), 32'(12'hFFF));
`endif
      check("red_flash_pattern", 32'(viol), 32'(0));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
